dm_cache_ctrl: RTL and testbench
================================

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 15, CPU word-address width.
REQ-002 SHALL have parameter WORD_LEN, default 32, data word width.
REQ-003 SHALL have parameter INDEX_LEN, default 10, giving 1024 lines; tag = ADDR_LEN-INDEX_LEN-2 bits.
REQ-004 SHALL have parameter MEM_LATENCY, default 1, range 1..15, wait cycles for a block fetch.
REQ-005 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-006 SHALL have ports (name, direction, width, meaning):
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 cpu_req  in  1  request valid, held until cpu_ready
 cpu_we  in  1  1 = write, 0 = read
 cpu_addr  in  ADDR_LEN  word address
 cpu_wdata  in  WORD_LEN  write data
 cpu_rdata  out  WORD_LEN  read data, valid when cpu_ready and !cpu_we
 cpu_ready  out  1  request complete this cycle
 mem_addr  out  ADDR_LEN  memory word address
 mem_read  out  1  block read strobe
 mem_write  out  1  word write strobe, one cycle
 mem_wdata  out  WORD_LEN  memory write data
 mem_rblock  in  4*WORD_LEN  4-word block, word k at bits [k*WORD_LEN +: WORD_LEN]

Function
REQ-007 SHALL be direct-mapped: offset=addr[1:0], index=addr[INDEX_LEN+1:2], tag=upper bits; line = valid, tag, 4 words.
REQ-008 SHALL implement FSM states IDLE, FETCH, FILL, WRITE.
REQ-009 IDLE, read hit: cpu_ready=1 combinationally, cpu_rdata=cached word; stay IDLE.
REQ-010 IDLE, read miss: cpu_ready=0; next state FETCH; latency counter loads MEM_LATENCY-1.
REQ-011 FETCH: mem_read=1, mem_addr={cpu_addr[ADDR_LEN-1:2],2'b00}; counter decrements; at 0 go FILL.
REQ-012 FILL: mem_read=1; write mem_rblock, tag, valid=1 into line; cpu_ready=1; cpu_rdata=selected word of mem_rblock; next IDLE.
REQ-013 Read miss total latency SHALL be MEM_LATENCY+1 cycles from request to cpu_ready.
REQ-014 Write policy SHALL be write-through, no-write-allocate: IDLE with cpu_req&cpu_we -> WRITE, cpu_ready=0.
REQ-015 WRITE: mem_write=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_ready=1; on hit update cached word; on miss line unchanged; next IDLE.
REQ-016 mem_read and mem_write SHALL never be high together; both 0 in IDLE.
REQ-017 Miss on a valid line SHALL overwrite it (no write-back needed).
REQ-018 cpu_req low in IDLE SHALL leave state, array and outputs idle (cpu_ready=0).
REQ-019 Input changes during FETCH SHALL be ignored; address latched on IDLE->FETCH/WRITE transition.

Reset
REQ-020 rst SHALL force state IDLE, clear all valid bits, clear latency counter, in the same edge.
REQ-021 Outputs after reset: cpu_ready=0, mem_read=0, mem_write=0, cpu_rdata=0, mem_addr=0, mem_wdata=0.
REQ-022 rst during FETCH/FILL/WRITE SHALL abort the transaction with no line written and no mem_write issued that cycle.

Configuration
REQ-023 Macro DM_CACHE_STATS_EN defined: SHALL add outputs hit_count and miss_count (32 bits, wrapping), cleared by rst; hit increments on REQ-009 completion, miss on IDLE->FETCH; writes not counted.
REQ-024 Without DM_CACHE_STATS_EN: SHALL have no counter ports or logic.

Structure
REQ-025 SHALL place widths, state enum and line struct (valid, tag, data[4]) in shared package cache_pkg.
REQ-026 SHALL use one sub-module cache_array (tag/valid/data storage, async read, sync write, bulk invalidate).

Verification
REQ-027 Reset then read 0x0400 with memory word[i]=i, MEM_LATENCY=1 -> cpu_ready after 2 cycles, cpu_rdata=0x400, miss_count=1.
REQ-028 Read 0x0401 immediately after -> cpu_ready same cycle, cpu_rdata=0x401, hit_count=1, mem_read stays 0.
REQ-029 Write 0xDEAD to 0x0402 (line cached) -> one-cycle mem_write, addr 0x402; next read 0x0402 hits with 0xDEAD.
REQ-030 Read 0x0400 then 0x1400 (same index, different tag) -> both miss; line replaced; re-read 0x0400 misses again.
REQ-031 MEM_LATENCY=3, assert rst in second FETCH cycle -> IDLE next cycle, outputs zero, re-read 0x0400 misses.
REQ-032 Write 0x55 to uncached 0x0800 -> mem_write pulse, no line allocated; read 0x0800 misses and returns 0x55.

Source files
------------

// File: rtl/dm_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped cache controller.
// Line storage widths (tag, word) come from the localparams here. The top
// level's parameter defaults track them.
package cache_pkg;

    localparam int CACHE_ADDR_LEN  = 15;
    localparam int CACHE_WORD_LEN  = 32;
    localparam int CACHE_INDEX_LEN = 10;
    localparam int CACHE_TAG_LEN   = CACHE_ADDR_LEN - CACHE_INDEX_LEN - 2;
    localparam int LINE_WORDS      = 4;
    localparam int CACHE_LINES     = 1 << CACHE_INDEX_LEN;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2,
        ST_WRITE = 2'd3
    } cache_state_t;

    typedef logic [LINE_WORDS-1:0][CACHE_WORD_LEN-1:0] line_data_t;

    typedef struct packed {
        logic                     valid;
        logic [CACHE_TAG_LEN-1:0] tag;
        line_data_t               data;
    } line_t;

endpackage

// File: rtl/dm_cache_ctrl_array.sv
// cache_array: tag/valid/data storage for the direct-mapped cache.
// Asynchronous line read, synchronous line fill or single-word update,
// and bulk invalidation of every valid bit on rst.
module cache_array
    import cache_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CACHE_INDEX_LEN-1:0]      index,
    output line_t                           rd_line,
    input  logic                            fill_en,
    input  logic [CACHE_TAG_LEN-1:0]        fill_tag,
    input  line_data_t                      fill_data,
    input  logic                            word_we,
    input  logic [1:0]                      word_offset,
    input  logic [CACHE_WORD_LEN-1:0]       word_data
);

    logic [CACHE_LINES-1:0]   valid_q;
    logic [CACHE_TAG_LEN-1:0] tag_mem  [CACHE_LINES];
    line_data_t               data_mem [CACHE_LINES];

    // Valid bits: cleared together on reset, set when a line is filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag and data storage: whole-line fill has priority over a word update.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[index]  <= fill_tag;
            data_mem[index] <= fill_data;
        end else if (word_we) begin
            data_mem[index][word_offset] <= word_data;
        end
    end

    // Asynchronous read of the addressed line.
    always_comb begin
        rd_line.valid = valid_q[index];
        rd_line.tag   = tag_mem[index];
        rd_line.data  = data_mem[index];
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, no-write-allocate cache
// controller with 4-word lines and a fixed-latency block fetch.
// Optional hit/miss counters are built when DM_CACHE_STATS_EN is defined.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_IDLE  | waiting; read hits complete here combinationally
//  ST_FETCH | block read issued, waiting MEM_LATENCY cycles
//  ST_FILL  | block arrives: line written, read completes
//  ST_WRITE | single-word write-through to memory, hit updates line
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_LEN    = CACHE_ADDR_LEN,
    parameter int WORD_LEN    = CACHE_WORD_LEN,
    parameter int INDEX_LEN   = CACHE_INDEX_LEN,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_LEN-1:0]   cpu_addr,
    input  logic [WORD_LEN-1:0]   cpu_wdata,
    output logic [WORD_LEN-1:0]   cpu_rdata,
    output logic                  cpu_ready,
    output logic [ADDR_LEN-1:0]   mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WORD_LEN-1:0]   mem_wdata,
    input  logic [4*WORD_LEN-1:0] mem_rblock
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int         TAG_LEN  = ADDR_LEN - INDEX_LEN - 2;
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    cache_state_t          state_q, state_d;
    logic [3:0]            lat_cnt_q, lat_cnt_d;
    logic [ADDR_LEN-1:0]   req_addr_q;
    logic [WORD_LEN-1:0]   req_wdata_q;
    logic                  latch_req;

    logic [ADDR_LEN-1:0]   cur_addr;
    logic [INDEX_LEN-1:0]  cur_index;
    logic [TAG_LEN-1:0]    cur_tag;
    logic [1:0]            cur_offset;
    logic [ADDR_LEN-1:0]   block_addr;

    line_t                 line_rd;
    logic                  line_hit;
    logic                  fill_en;
    logic                  word_we;

    // In IDLE the live request is looked up; afterwards the latched one,
    // so CPU-side changes mid-transaction cannot disturb it.
    always_comb begin
        cur_addr   = (state_q == ST_IDLE) ? cpu_addr : req_addr_q;
        cur_offset = cur_addr[1:0];
        cur_index  = cur_addr[INDEX_LEN+1:2];
        cur_tag    = cur_addr[ADDR_LEN-1:INDEX_LEN+2];
        block_addr = {req_addr_q[ADDR_LEN-1:2], 2'b00};
        line_hit   = line_rd.valid && (line_rd.tag == cur_tag);
    end

    cache_array u_array (
        .clk         (clk),
        .rst         (rst),
        .index       (cur_index),
        .rd_line     (line_rd),
        .fill_en     (fill_en),
        .fill_tag    (cur_tag),
        .fill_data   (mem_rblock),
        .word_we     (word_we),
        .word_offset (cur_offset),
        .word_data   (req_wdata_q)
    );

    // State, latency counter and request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            if (latch_req) begin
                req_addr_q  <= cpu_addr;
                req_wdata_q <= cpu_wdata;
            end
        end
    end

    // Next state and outputs; rst forces everything quiet in its own cycle
    // so an aborted transaction writes neither the array nor memory.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        latch_req = 1'b0;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        fill_en   = 1'b0;
        word_we   = 1'b0;
        if (rst) begin
            state_d   = ST_IDLE;
            lat_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (cpu_we) begin
                            state_d   = ST_WRITE;
                            latch_req = 1'b1;
                        end else if (line_hit) begin
                            cpu_ready = 1'b1;
                            cpu_rdata = line_rd.data[cur_offset];
                        end else begin
                            state_d   = ST_FETCH;
                            lat_cnt_d = LAT_LOAD;
                            latch_req = 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    mem_read = 1'b1;
                    mem_addr = block_addr;
                    if (lat_cnt_q == 4'd0) begin
                        state_d = ST_FILL;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 4'd1;
                    end
                end
                ST_FILL: begin
                    mem_read  = 1'b1;
                    mem_addr  = block_addr;
                    fill_en   = 1'b1;
                    cpu_ready = 1'b1;
                    cpu_rdata = mem_rblock[cur_offset*WORD_LEN +: WORD_LEN];
                    state_d   = ST_IDLE;
                end
                ST_WRITE: begin
                    mem_write = 1'b1;
                    mem_addr  = req_addr_q;
                    mem_wdata = req_wdata_q;
                    cpu_ready = 1'b1;
                    word_we   = line_hit;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

`ifdef DM_CACHE_STATS_EN
    logic hit_evt;
    logic miss_evt;

    // A hit is a read completing in IDLE; a miss is the IDLE->FETCH step.
    always_comb begin
        hit_evt  = !rst && (state_q == ST_IDLE) && cpu_req && !cpu_we && line_hit;
        miss_evt = !rst && (state_q == ST_IDLE) && (state_d == ST_FETCH);
    end

    // Wrapping hit/miss counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_evt) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_evt) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: a MEM_LATENCY=1 instance driven from a vector
// table plus reset/abort sequences, and a MEM_LATENCY=3 instance for the
// longer-latency miss and reset-during-FETCH cases.
module tb_dm_cache_ctrl;

    localparam int AW = 15;
    localparam int WW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // MEM_LATENCY = 1 instance
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [WW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_read, mem_write;
    logic [WW-1:0] mem_wdata;
    logic [4*WW-1:0] mem_rblock;

    // MEM_LATENCY = 3 instance
    logic          rst3;
    logic          req3, we3;
    logic [AW-1:0] addr3;
    logic [WW-1:0] wdata3, rdata3;
    logic          ready3;
    logic [AW-1:0] maddr3;
    logic          mread3, mwrite3;
    logic [WW-1:0] mwdata3;
    logic [4*WW-1:0] rblock3;

`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count, hit_count3, miss_count3;
`endif

    logic [WW-1:0] mem_model [1<<AW];

    int checks = 0;
    int errors = 0;
    int excl_viol = 0;

    dm_cache_ctrl #(.MEM_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rblock(mem_rblock)
`ifdef DM_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    dm_cache_ctrl #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3), .cpu_req(req3), .cpu_we(we3),
        .cpu_addr(addr3), .cpu_wdata(wdata3), .cpu_rdata(rdata3),
        .cpu_ready(ready3), .mem_addr(maddr3), .mem_read(mread3),
        .mem_write(mwrite3), .mem_wdata(mwdata3), .mem_rblock(rblock3)
`ifdef DM_CACHE_STATS_EN
        , .hit_count(hit_count3), .miss_count(miss_count3)
`endif
    );

    // Memory model: word i initially holds i; block reads are combinational.
    always_comb begin
        mem_rblock = '0;
        rblock3    = '0;
        for (int k = 0; k < 4; k++) begin
            mem_rblock[k*WW +: WW] = mem_model[{mem_addr[AW-1:2], 2'(k)}];
            rblock3[k*WW +: WW]    = mem_model[{maddr3[AW-1:2], 2'(k)}];
        end
    end

    always @(posedge clk) begin
        if (mem_write) mem_model[mem_addr] <= mem_wdata;
        if (mwrite3)   mem_model[maddr3]   <= mwdata3;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One CPU transaction on the latency-1 instance; called just after a
    // rising edge, returns just after the edge that ends the ready cycle.
    task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] wd,
                          output logic [WW-1:0] rd, output int lat, output int nrd,
                          output int nwr, output logic [AW-1:0] waddr, output logic [WW-1:0] wdat);
        rd = '0; lat = 0; nrd = 0; nwr = 0; waddr = '0; wdat = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) excl_viol++;
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++; waddr = mem_addr; wdat = mem_wdata;
            end
            if (cpu_ready) begin
                rd = cpu_rdata;
                break;
            end
            lat++;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    // Read on the latency-3 instance.
    task automatic op3(input logic [AW-1:0] addr, output logic [WW-1:0] rd, output int lat);
        rd = '0; lat = 0;
        req3 = 1'b1; we3 = 1'b0; addr3 = addr;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready3) begin
                rd = rdata3;
                break;
            end
            lat++;
        end
        @(posedge clk); #1;
        req3 = 1'b0;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
        logic [WW-1:0] exp_rd;
        int            exp_lat;
        int            exp_nrd;
        int            exp_nwr;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [WW-1:0] rd;
        logic [AW-1:0] waddr;
        logic [WW-1:0] wdat;
        int lat, nrd, nwr;
        int exp_hits, exp_misses;

        //         we    addr       wdata         exp_rd        lat nrd nwr
        vecs[0]  = '{1'b0, 15'h0400, 32'h0,        32'h0000_0400, 2, 2, 0};
        vecs[1]  = '{1'b0, 15'h0401, 32'h0,        32'h0000_0401, 0, 0, 0};
        vecs[2]  = '{1'b1, 15'h0402, 32'h0000_DEAD, 32'h0,        1, 0, 1};
        vecs[3]  = '{1'b0, 15'h0402, 32'h0,        32'h0000_DEAD, 0, 0, 0};
        vecs[4]  = '{1'b0, 15'h1400, 32'h0,        32'h0000_1400, 2, 2, 0};
        vecs[5]  = '{1'b0, 15'h0400, 32'h0,        32'h0000_0400, 2, 2, 0};
        vecs[6]  = '{1'b1, 15'h0800, 32'h0000_0055, 32'h0,        1, 0, 1};
        vecs[7]  = '{1'b0, 15'h0800, 32'h0,        32'h0000_0055, 2, 2, 0};
        vecs[8]  = '{1'b0, 15'h0802, 32'h0,        32'h0000_0802, 0, 0, 0};
        vecs[9]  = '{1'b1, 15'h1401, 32'h0000_BEEF, 32'h0,        1, 0, 1};
        vecs[10] = '{1'b0, 15'h0401, 32'h0,        32'h0000_0401, 0, 0, 0};
        vecs[11] = '{1'b0, 15'h1401, 32'h0,        32'h0000_BEEF, 2, 2, 0};
        vecs[12] = '{1'b0, 15'h7FFF, 32'h0,        32'h0000_7FFF, 2, 2, 0};
        vecs[13] = '{1'b0, 15'h7FFC, 32'h0,        32'h0000_7FFC, 0, 0, 0};

        for (int i = 0; i < (1 << AW); i++) mem_model[i] <= WW'(i);

        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0;
        rst = 1'b1; rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; rst3 = 1'b0;

        // Outputs straight out of reset
        @(negedge clk);
        check("rst_cpu_ready", {31'b0, cpu_ready}, 32'h0);
        check("rst_mem_read",  {31'b0, mem_read},  32'h0);
        check("rst_mem_write", {31'b0, mem_write}, 32'h0);
        check("rst_cpu_rdata", cpu_rdata,          32'h0);
        check("rst_mem_addr",  {17'b0, mem_addr},  32'h0);
        check("rst_mem_wdata", mem_wdata,          32'h0);
`ifdef DM_CACHE_STATS_EN
        check("rst_hit_count",  hit_count,  32'h0);
        check("rst_miss_count", miss_count, 32'h0);
`endif
        @(posedge clk); #1;

        exp_hits = 0; exp_misses = 0;
        for (int v = 0; v < 14; v++) begin
            cpu_op(vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, lat, nrd, nwr, waddr, wdat);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_mem_read_cycles", v), 32'(nrd), 32'(vecs[v].exp_nrd));
            check($sformatf("v%0d_mem_write_cycles", v), 32'(nwr), 32'(vecs[v].exp_nwr));
            if (vecs[v].we) begin
                check($sformatf("v%0d_mem_addr", v), {17'b0, waddr}, {17'b0, vecs[v].addr});
                check($sformatf("v%0d_mem_wdata", v), wdat, vecs[v].wdata);
            end else begin
                check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
                if (vecs[v].exp_lat == 0) exp_hits++;
                else exp_misses++;
            end
`ifdef DM_CACHE_STATS_EN
            check($sformatf("v%0d_hit_count", v), hit_count, 32'(exp_hits));
            check($sformatf("v%0d_miss_count", v), miss_count, 32'(exp_misses));
`endif
        end

        // Idle with a cached address on the bus but no request
        cpu_addr = 15'h0401;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_no_req_ready", {31'b0, cpu_ready}, 32'h0);
            check("idle_no_req_mem_read", {31'b0, mem_read}, 32'h0);
        end
        @(posedge clk); #1;

        // Reset arriving in the WRITE cycle aborts the write-through
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0403; cpu_wdata = 32'h0000_1234;
        @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        check("rst_in_write_mem_write", {31'b0, mem_write}, 32'h0);
        check("rst_in_write_ready", {31'b0, cpu_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_op(1'b0, 15'h0403, '0, rd, lat, nrd, nwr, waddr, wdat);
        check("after_abort_rdata", rd, 32'h0000_0403);
        check("after_abort_latency", 32'(lat), 32'd2);
        cpu_op(1'b0, 15'h7FFC, '0, rd, lat, nrd, nwr, waddr, wdat);
        check("invalidated_latency", 32'(lat), 32'd2);
        check("invalidated_rdata", rd, 32'h0000_7FFC);
        check("rd_wr_exclusive", 32'(excl_viol), 32'd0);

        // Latency-3 instance: miss takes MEM_LATENCY+1 cycles
        op3(15'h0400, rd, lat);
        check("l3_miss_latency", 32'(lat), 32'd4);
        check("l3_miss_rdata", rd, 32'h0000_0400);
        op3(15'h0400, rd, lat);
        check("l3_hit_latency", 32'(lat), 32'd0);

        // Reset in the second FETCH cycle
        req3 = 1'b1; we3 = 1'b0; addr3 = 15'h0800;
        @(posedge clk); #1;
        @(negedge clk);
        check("l3_fetch1_mem_read", {31'b0, mread3}, 32'h1);
        check("l3_fetch1_mem_addr", {17'b0, maddr3}, 32'h0800);
        @(posedge clk); #1;
        rst3 = 1'b1; req3 = 1'b0;
        @(negedge clk);
        check("l3_rst_cycle_mem_read", {31'b0, mread3}, 32'h0);
        check("l3_rst_cycle_ready", {31'b0, ready3}, 32'h0);
        @(posedge clk); #1;
        rst3 = 1'b0;
        @(negedge clk);
        check("l3_after_rst_outputs", {mread3, mwrite3, ready3, maddr3}, 32'h0);
        check("l3_after_rst_rdata", rdata3, 32'h0);
        @(posedge clk); #1;
        op3(15'h0400, rd, lat);
        check("l3_reread_latency", 32'(lat), 32'd4);
        check("l3_reread_rdata", rd, 32'h0000_0400);
        op3(15'h0800, rd, lat);
        check("l3_aborted_line_latency", 32'(lat), 32'd4);
        check("l3_aborted_line_rdata", rd, 32'h0000_0055);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
